morph_window_ctrl: RTL

//  Frame/line sequencer for the 3x3 morphology datapath (dilation/erosion) in the camera pipe.

---
 rtl/morph_window_if.sv | 29 ++
 rtl/morph_window_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/morph_window_if.sv
// Handshake bundle between the camera pipe and the 3x3 morphology window sequencer.
interface morph_window_if #(
  parameter int unsigned XW = 12,
  parameter int unsigned YW = 12
);
  logic          fval;
  logic          dval;
  logic [1:0]    mode;
  logic          lb_clken;
  logic          win_valid;
  logic          border;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    op;
  logic [XW-1:0] width;
  logic [YW-1:0] height;
  logic          frame_done;
  logic          busy;
  logic          line_err;

  modport master (
    output fval, dval, mode,
    input  lb_clken, win_valid, border, x, y, op, width, height, frame_done, busy, line_err
  );
  modport slave (
    input  fval, dval, mode,
    output lb_clken, win_valid, border, x, y, op, width, height, frame_done, busy, line_err
  );
endinterface

// File: rtl/morph_window_ctrl.sv
// Frame/line sequencer for the 3x3 morphology datapath: pixel x/y tracking, window-valid
// flagging, per-frame op latch and frame size / line-length checks. Option: MORPH_CTRL_BORDER_EN.
module morph_window_ctrl #(
  parameter int unsigned XW    = 12,
  parameter int unsigned YW    = 12,
  parameter int unsigned KSIZE = 3
) (
  input logic            clk,
  input logic            rst_n,
  morph_window_if.slave  bus
);
  localparam int unsigned Fill = KSIZE - 1;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic          fval_q, dval_q;
  logic [XW-1:0] x_q, x_d, xo_q, width_q, width_d;
  logic [YW-1:0] y_q, y_d, yo_q, height_q, height_d;
  logic [1:0]    op_q, op_d;
  logic          err_q, err_d, win_q, win_d, border_q, border_d;

  logic          fval_rise, start, in_frame, frame_act, acc, line_end, x_ok, y_ok;
  logic [XW-1:0] x_eff;
  logic [YW-1:0] y_eff;

  assign fval_rise = bus.fval & ~fval_q;
  assign start     = (state_q == StIdle) & fval_rise;
  assign in_frame  = (state_q == StFill) | (state_q == StRun);
  assign frame_act = (state_q != StIdle) | fval_rise;
  assign acc       = bus.dval & frame_act & bus.fval;
  assign line_end  = in_frame & dval_q & ~bus.dval;
  // A pixel accepted in the frame-start cycle sits at (0,0) even though x_q/y_q are stale.
  assign x_eff     = start ? '0 : x_q;
  assign y_eff     = start ? '0 : y_q;
  assign x_ok      = x_eff >= XW'(Fill);
  assign y_ok      = y_eff >= YW'(Fill);

  always_comb begin
    state_d  = state_q;
    x_d      = x_eff;
    y_d      = y_eff;
    width_d  = width_q;
    height_d = height_q;
    op_d     = op_q;
    err_d    = start ? 1'b0 : err_q;
    if (acc) begin
      if (x_eff == {XW{1'b1}}) err_d = 1'b1;
      else                     x_d   = x_eff + XW'(1);
    end
    if (line_end) begin
      x_d = '0;
      y_d = y_q + YW'(1);
      if (y_q == '0)            width_d = x_q;
      else if (x_q != width_q)  err_d   = 1'b1;
    end
    unique case (state_q)
      StIdle: if (fval_rise) begin
        state_d = StFill;
        op_d    = (bus.mode == 2'b11) ? 2'b00 : bus.mode;
      end
      StFill: begin
        if (!bus.fval)              state_d = StDone;
        else if (y_d >= YW'(Fill))  state_d = StRun;
      end
      StRun:  if (!bus.fval) state_d = StDone;
      StDone: begin
        state_d  = StIdle;
        // Count a trailing line that never saw its iDVAL fall.
        height_d = y_q + {{(YW-1){1'b0}}, (x_q != '0)};
      end
      default: state_d = StIdle;
    endcase
`ifdef MORPH_CTRL_BORDER_EN
    win_d    = acc;
    border_d = acc & ~(x_ok & y_ok);
`else
    win_d    = acc & x_ok & y_ok;
    border_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      fval_q   <= 1'b1;
      dval_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xo_q     <= '0;
      yo_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
      op_q     <= 2'b00;
      err_q    <= 1'b0;
      win_q    <= 1'b0;
      border_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fval_q   <= bus.fval;
      dval_q   <= bus.dval;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      op_q     <= op_d;
      err_q    <= err_d;
      win_q    <= win_d;
      border_q <= border_d;
      if (acc) begin
        xo_q <= x_eff;
        yo_q <= y_eff;
      end
    end
  end

  assign bus.lb_clken   = acc;
  assign bus.win_valid  = win_q;
  assign bus.border     = border_q;
  assign bus.x          = xo_q;
  assign bus.y          = yo_q;
  assign bus.op         = op_q;
  assign bus.width      = width_q;
  assign bus.height     = height_q;
  assign bus.frame_done = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.line_err   = err_q;
endmodule
